// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seqdet_pkg;

  typedef enum logic {
    MODE_RESTART = 1'b0,
    MODE_OVERLAP = 1'b1
  } seqdet_mode_e;

  localparam int DEFAULT_CNT_W = 8;

  // Width needed to hold a matched-prefix length in the range 0..pat_w
  function automatic int clog2_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seqdet_match_counter.sv
// Saturating match counter; a clear on the same edge as a match wins.
module seqdet_match_counter
  import seqdet_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detect,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (detect && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seqdetector_param.sv
// Runtime-programmable serial sequence detector with KMP-style prefix tracking.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seqdetector_param
  import seqdet_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = DEFAULT_CNT_W,
  localparam int            SW      = clog2_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             X,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             detect,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count
);

  localparam int VW = PAT_W + 1;
  localparam logic [VW-1:0] ONES = '1;

  logic [PAT_W-1:0] pat_reg;
  logic [VW-1:0]    pat_lsb;
  logic [VW-1:0]    hist_vec;
  int               match_len;
  int               border_len;
  logic             hit;
  logic [SW-1:0]    state_nxt;

  // The matched prefix plus the new bit is rebuilt from the pattern itself (first-received bit at
  // index 0), so the longest prefix/suffix overlap is found directly without a precomputed table.
  always_comb begin
    pat_lsb = '0;
    for (int i = 0; i < PAT_W; i++) begin
      pat_lsb[i] = pat_reg[PAT_W-1-i];
    end
    hist_vec = (pat_lsb & ~(ONES << state)) | (VW'(X) << state);

    match_len = 0;
    for (int k = 1; k <= PAT_W; k++) begin
      if ((k <= int'(state) + 1) &&
          (((hist_vec >> (int'(state) + 1 - k)) & ~(ONES << k)) == (pat_lsb & ~(ONES << k)))) begin
        match_len = k;
      end
    end

    border_len = 0;
    for (int k = 1; k < PAT_W; k++) begin
      if (((pat_lsb >> (PAT_W - k)) & ~(ONES << k)) == (pat_lsb & ~(ONES << k))) begin
        border_len = k;
      end
    end

    hit = (match_len == PAT_W);
    if (hit) begin
      state_nxt = (overlap == MODE_OVERLAP) ? SW'(border_len) : '0;
    end else begin
      state_nxt = SW'(match_len);
    end
  end

  // A pattern load restarts the search and discards the bit presented on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg <= PATTERN;
      state   <= '0;
      detect  <= 1'b0;
    end else if (pat_load) begin
      pat_reg <= pat_in;
      state   <= '0;
      detect  <= 1'b0;
    end else if (en) begin
      state  <= state_nxt;
      detect <= hit;
    end else begin
      detect <= 1'b0;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic count_hit;
  assign count_hit = en & ~pat_load & hit;

  seqdet_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .detect     (count_hit),
    .cnt_clr    (cnt_clr),
    .match_count(match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule
